// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: sequencer state
// encoding, supported opcodes, datapath mux encodings and the control vector.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StAluWb,
    StBranch
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       ior_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_sel;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(logic [6:0] op);
    return (op == OpR) || (op == OpLoad) || (op == OpStore) || (op == OpBranch);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational output decoder for the multi-cycle control unit.
// Ports:
//   state_i     current sequencer state
//   opcode_i    IR[6:0], meaningful in DECODE and MEM_ADDR
//   mem_ready_i memory handshake, gates fetch strobes and store completion
//   rst_ni      active-low reset; while low every strobe is held at 0
//   ctrl_o      full datapath control vector
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       rst_ni,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_a = SrcAPc;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = AluAdd;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        // Branch target computed speculatively into ALUOut.
        ctrl_o.alu_src_a = SrcAOldPc;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.imm_sel   = ImmB;
        ctrl_o.alu_op    = AluAdd;
        if (!is_legal_op(opcode_i)) begin
          ctrl_o.illegal_op = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
      end
      StMemAddr: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
        ctrl_o.imm_sel   = (opcode_i == OpStore) ? ImmS : ImmI;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ior_d    = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.ior_d      = 1'b1;
        ctrl_o.imm_sel    = ImmS;
        ctrl_o.instr_done = mem_ready_i;
      end
      StExecR: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBRs2;
        ctrl_o.alu_op    = AluFunct;
      end
      StAluWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = SrcARs1;
        ctrl_o.alu_src_b     = SrcBRs2;
        ctrl_o.alu_op        = AluSub;
        ctrl_o.imm_sel       = ImmB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 1'b1;
        ctrl_o.instr_done    = 1'b1;
      end
      default: ;
    endcase

    // State is already FETCH during reset, so selects are correct; only the
    // strobes need suppressing so no write leaks out while reset is asserted.
    if (!rst_ni) begin
      ctrl_o.pc_write      = 1'b0;
      ctrl_o.pc_write_cond = 1'b0;
      ctrl_o.ir_write      = 1'b0;
      ctrl_o.mem_read      = 1'b0;
      ctrl_o.mem_write     = 1'b0;
      ctrl_o.reg_write     = 1'b0;
      ctrl_o.instr_done    = 1'b0;
      ctrl_o.illegal_op    = 1'b0;
    end
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Moore sequencing FSM for the multi-cycle RV32I datapath. Holds the state
// register and next-state logic; output decoding lives in mc_output_decode.
// Ports: clk, rst_n (async active-low), opcode (IR[6:0]), mem_ready
// (memory handshake); outputs are datapath mux selects, register/memory
// strobes, instr_done (last cycle of each instruction) and illegal_op.
module multi_cycle_control_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcSource,
  output logic       iorD,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] immSel,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpR:              state_d = StExecR;
          OpLoad, OpStore:  state_d = StMemAddr;
          OpBranch:         state_d = StBranch;
          default:          state_d = StFetch;
        endcase
      end
      StMemAddr:  state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .rst_ni      (rst_n),
    .ctrl_o      (ctrl)
  );

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign pcSource    = ctrl.pc_source;
  assign iorD        = ctrl.ior_d;
  assign irWrite     = ctrl.ir_write;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign memToReg    = ctrl.mem_to_reg;
  assign regWrite    = ctrl.reg_write;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign aluOp       = ctrl.alu_op;
  assign immSel      = ctrl.imm_sel;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pcWrite, pcWriteCond, pcSource, iorD, irWrite, memRead, memWrite;
  logic       memToReg, regWrite, instr_done, illegal_op;
  logic [1:0] aluSrcA, aluSrcB, aluOp, immSel;

  always #5 clk = ~clk;

  multi_cycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource), .iorD(iorD),
    .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .immSel(immSel), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       pcw, pcwc, pcsrc, iord, irw, mrd, mwr, m2r, rw;
    logic [1:0] srca, srcb, aop, imm;
    logic       done, ill;
  } vec_t;

  typedef struct {
    logic       mr;
    logic [6:0] op;
    string      step;
    vec_t       exp;
  } row_t;

  vec_t act;
  assign act = {pcWrite, pcWriteCond, pcSource, iorD, irWrite, memRead, memWrite, memToReg,
                regWrite, aluSrcA, aluSrcB, aluOp, immSel, instr_done, illegal_op};

  row_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_lat = 0;

  // Output vector each named step must produce, straight from the step table.
  function automatic vec_t expect_for(string step, logic mr, logic is_store);
    vec_t v = '0;
    case (step)
      "fetch":     begin v.mrd = 1; v.srcb = 2'b01; v.irw = mr; v.pcw = mr; end
      "decode":    begin v.srca = 2'b01; v.srcb = 2'b10; v.imm = 2'b10; end
      "illegal":   begin v.srca = 2'b01; v.srcb = 2'b10; v.imm = 2'b10;
                         v.ill = 1; v.done = 1; end
      "mem_addr":  begin v.srca = 2'b10; v.srcb = 2'b10; v.imm = is_store ? 2'b01 : 2'b00; end
      "mem_read":  begin v.mrd = 1; v.iord = 1; end
      "mem_wb":    begin v.rw = 1; v.m2r = 1; v.done = 1; end
      "mem_write": begin v.mwr = 1; v.iord = 1; v.imm = 2'b01; v.done = mr; end
      "exec_r":    begin v.srca = 2'b10; v.srcb = 2'b00; v.aop = 2'b10; end
      "alu_wb":    begin v.rw = 1; v.done = 1; end
      "branch":    begin v.srca = 2'b10; v.aop = 2'b01; v.imm = 2'b10;
                         v.pcwc = 1; v.pcsrc = 1; v.done = 1; end
      default:     v = 'x;
    endcase
    return v;
  endfunction

  function automatic vec_t reset_vec();
    vec_t v = '0;
    v.srcb = 2'b01;
    return v;
  endfunction

  task automatic push(string step, logic mr, logic [6:0] op);
    row_t r;
    r.mr = mr; r.op = op; r.step = step;
    r.exp = expect_for(step, mr, op == ST_OP);
    q.push_back(r);
  endtask

  // Expand one instruction into its cycle script; wf/wm are wait cycles in
  // fetch and in the memory step. Fetch rows carry a garbage opcode.
  task automatic add_instr(logic [6:0] op, int wf, int wm);
    for (int i = 0; i < wf; i++) push("fetch", 1'b0, 7'($urandom));
    push("fetch", 1'b1, 7'($urandom));
    if (op == R_OP) begin
      push("decode", 1'($urandom), op); push("exec_r", 1'($urandom), op);
      push("alu_wb", 1'($urandom), op);
    end else if (op == LD_OP) begin
      push("decode", 1'($urandom), op); push("mem_addr", 1'($urandom), op);
      for (int i = 0; i < wm; i++) push("mem_read", 1'b0, op);
      push("mem_read", 1'b1, op); push("mem_wb", 1'($urandom), op);
    end else if (op == ST_OP) begin
      push("decode", 1'($urandom), op); push("mem_addr", 1'($urandom), op);
      for (int i = 0; i < wm; i++) push("mem_write", 1'b0, op);
      push("mem_write", 1'b1, op);
    end else if (op == BR_OP) begin
      push("decode", 1'($urandom), op); push("branch", 1'($urandom), op);
    end else begin
      push("illegal", 1'($urandom), op);
    end
  endtask

  task automatic check_vec(string name, vec_t a, vec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, a, e);
    end
  endtask

  task automatic check_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, a, e);
    end
  endtask

  // Called at posedge+1; runs n rows (all if n < 0), returns at posedge+1.
  task automatic run(int n);
    int count = 0;
    row_t r;
    while (q.size() > 0 && (n < 0 || count < n)) begin
      r = q.pop_front();
      mem_ready = r.mr;
      opcode    = r.op;
      @(negedge clk);
      check_vec(r.step, act, r.exp);
      checks++;
      if (act.mrd && act.mwr) begin
        errors++;
        $display("FAIL rd_wr_overlap: got memRead=1 memWrite=1 want not both");
      end
      checks++;
      if (act.rw && act.mwr) begin
        errors++;
        $display("FAIL rw_wr_overlap: got regWrite=1 memWrite=1 want not both");
      end
      cyc++;
      if (act.done) begin
        last_lat = cyc;
        cyc = 0;
      end
      @(posedge clk);
      #1;
      count++;
    end
  endtask

  task automatic directed(string name, logic [6:0] op, int wf, int wm, int lat);
    last_lat = 0;
    cyc = 0;
    add_instr(op, wf, wm);
    run(-1);
    check_int(name, last_lat, lat);
  endtask

  initial begin
    mem_ready = 1'b1;
    opcode    = R_OP;
    #2;
    check_vec("reset_outputs", act, reset_vec());
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_held_clocked", act, reset_vec());
    rst_n = 1'b1;

    directed("lat_rtype",   R_OP,    0, 0, 4);
    directed("lat_load",    LD_OP,   0, 0, 5);
    directed("lat_load_w2", LD_OP,   0, 2, 7);
    directed("lat_store",   ST_OP,   0, 0, 4);
    directed("lat_branch",  BR_OP,   0, 0, 3);
    directed("lat_illegal", 7'h7F,   0, 0, 2);
    directed("lat_fetch_w1_r", R_OP, 1, 0, 5);

    // Reset pulsed while a store is stalled in its write step.
    add_instr(ST_OP, 0, 5);
    run(4);
    mem_ready = 1'b0;
    opcode    = ST_OP;
    #1;
    checks++;
    if (memWrite !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_memwrite: got %b want 1", memWrite);
    end
    rst_n = 1'b0;
    #1;
    check_vec("async_reset_mid_store", act, reset_vec());
    @(posedge clk);
    #1;
    check_vec("reset_mid_store_held", act, reset_vec());
    q.delete();
    rst_n = 1'b1;
    directed("post_reset_branch", BR_OP, 0, 0, 3);

    for (int k = 0; k < 40; k++) begin
      logic [6:0] op;
      case ($urandom_range(0, 4))
        0: op = R_OP;
        1: op = LD_OP;
        2: op = ST_OP;
        3: op = BR_OP;
        default: op = 7'($urandom);
      endcase
      add_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    run(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_unit.md
# multi_cycle_control_unit

Moore-style sequencing FSM for the multi-cycle RV32I datapath (shared ALU, unified instruction/data memory, IR/oldPC/ALUOut/MDR registers). It walks each instruction through fetch, decode, execute, memory and writeback steps, stalling on memory handshakes. It drives every datapath mux select and register-write strobe, and supports R-type, load, store and branch (BEQ-class) opcodes.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  rising-edge system clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load when ALU zero flag is set
- pcSource  out  1  0 = ALU result, 1 = ALUOut
- iorD  out  1  memory address: 0 = PC, 1 = ALUOut
- irWrite  out  1  load IR and oldPC from memory/PC
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- memToReg  out  1  writeback: 0 = ALUOut, 1 = MDR
- regWrite  out  1  register file write
- aluSrcA  out  2  00 = PC, 01 = oldPC, 10 = rs1
- aluSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- aluOp  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- immSel  out  2  00 = I, 01 = S, 10 = B
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
Opcodes: R = 0110011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011.

States and their outputs. Any output not listed is 0. immSel is 00 unless listed.
- FETCH: memRead=1, iorD=0, aluSrcA=00, aluSrcB=01, aluOp=00, pcSource=0, irWrite=pcWrite=mem_ready. Go to DECODE when mem_ready; otherwise hold.
- DECODE: aluSrcA=01, aluSrcB=10, immSel=10, aluOp=00. This speculatively computes the branch target into ALUOut.
  - R → EXEC_R; LOAD/STORE → MEM_ADDR; BRANCH → BRANCH.
  - Any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- MEM_ADDR: aluSrcA=10, aluSrcB=10, aluOp=00, immSel = 00 for LOAD or 01 for STORE. LOAD → MEM_READ; STORE → MEM_WRITE.
- MEM_READ: memRead=1, iorD=1. Go to MEM_WB when mem_ready; otherwise hold.
- MEM_WB: regWrite=1, memToReg=1, instr_done=1. Go to FETCH.
- MEM_WRITE: memWrite=1, iorD=1, immSel=01. When mem_ready: instr_done=1 and go to FETCH; otherwise hold.
- EXEC_R: aluSrcA=10, aluSrcB=00, aluOp=10. Go to ALU_WB.
- ALU_WB: regWrite=1, memToReg=0, instr_done=1. Go to FETCH.
- BRANCH: aluSrcA=10, aluSrcB=00, aluOp=01, immSel=10, pcWriteCond=1, pcSource=1, instr_done=1. Go to FETCH.

Rules:
- opcode is sampled only in DECODE and MEM_ADDR. It is a don't-care in all other states.
- memRead and memWrite are never high in the same cycle.
- regWrite is never high in the same cycle as memWrite.

## Timing
- State register is clocked on the rising edge of clk.
- Outputs are combinational from the state, plus mem_ready gating where stated above.
- Reset (rst_n low):
  - State goes to FETCH asynchronously.
  - All strobes are forced to 0: pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite, instr_done, illegal_op.
  - All select outputs take their FETCH values.
- Reset deassertion: the first rising edge with rst_n high is a FETCH cycle.
- Reset asserted mid-instruction: the instruction is abandoned, with no partial register or memory write after the assertion.
- Latency with zero wait-states (mem_ready held high), in cycles:
  - R-type: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Illegal opcode: 2.
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs hold stable during a stall.
- instr_done rises exactly once per instruction, including illegal ones.

## Structure
- Shared package `mc_pkg` holds:
  - the state enum (9 states);
  - opcode localparams;
  - encodings for aluSrcA, aluSrcB, aluOp and immSel.
- One sub-module, `mc_output_decode`: purely combinational, maps (state, opcode, mem_ready) to the output vector.
- The top level contains only the state register and the next-state logic.

## Test plan
- Reset, then R-type (opcode 0110011) with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB. Exactly one regWrite=1, with memToReg=0. instr_done on cycle 4.
- LOAD with mem_ready low for 2 cycles in MEM_READ:
  - memRead and iorD=1 are held for 3 cycles.
  - 7 cycles in total.
  - MEM_WB shows regWrite=1 and memToReg=1.
- STORE → MEM_ADDR shows immSel=01. MEM_WRITE shows memWrite=1 and regWrite=0 throughout. Back in FETCH on cycle 5.
- BRANCH → DECODE shows aluSrcA=01, aluSrcB=10, immSel=10. BRANCH shows pcWriteCond=1 and pcSource=1. Total 3 cycles.
- Opcode 1111111 → illegal_op=1 and instr_done=1 in DECODE, then FETCH. No regWrite or memWrite at any point.
- rst_n pulsed low during MEM_WRITE → state is FETCH immediately, memWrite drops to 0 asynchronously, and the first post-reset cycle is FETCH.
